// File: rtl/int_dispatch.sv
// CPU-side interrupt sequencer: IME/EI delay/DI/RETI, HALT wake, and the
// 5 M-cycle interrupt dispatch (idle, idle, push PCH, push PCL, jump).
module int_dispatch #(
   parameter int MCYCLE = 4
) (
   input  logic        clockgb,
   input  logic        resetn,
   input  logic        intreq,
   input  logic [15:0] intaddress,
   output logic        intack,
   input  logic        boundary,
   input  logic        ei,
   input  logic        di,
   input  logic        reti,
   input  logic        halt,
   input  logic [15:0] pc,
   input  logic [15:0] sp,
   output logic        take,
   output logic        halted,
   output logic        ime,
   output logic        wr,
   output logic [15:0] wraddr,
   output logic [7:0]  wrdata,
   output logic        pc_load,
   output logic        sp_load,
   output logic [15:0] newpc,
   output logic [15:0] newsp
);

   localparam int CW = $clog2(MCYCLE);
   localparam logic [CW-1:0] CLAST = CW'(MCYCLE - 1);

   typedef enum logic [2:0] {S_IDLE, S_M1, S_M2, S_M3, S_M4, S_M5} state_t;

   state_t          st_q, st_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            ime_q, ei_pend_q, halted_q;
   logic [15:0]     pcl_q, spl_q, vec_q;
   logic            wr_q, pc_load_q, sp_load_q;
   logic [15:0]     wraddr_q, newpc_q, newsp_q;
   logic [7:0]      wrdata_q;
   logic            bnd, eff_ime, start;

   always_comb begin
      bnd     = boundary && (st_q == S_IDLE) && !halted_q;
      eff_ime = (ime_q | ei_pend_q | reti) & ~di;
      // A halted CPU wakes straight into dispatch when IME is already set.
      start   = (bnd && eff_ime && intreq) || (halted_q && intreq && ime_q);
      st_d    = st_q;
      cnt_d   = cnt_q;
      if (start) begin
         st_d  = S_M1;
         cnt_d = '0;
      end else if (st_q != S_IDLE) begin
         if (cnt_q == CLAST) begin
            cnt_d = '0;
            case (st_q)
               S_M1:    st_d = S_M2;
               S_M2:    st_d = S_M3;
               S_M3:    st_d = S_M4;
               S_M4:    st_d = S_M5;
               default: st_d = S_IDLE;
            endcase
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clockgb or negedge resetn) begin
      if (!resetn) begin
         st_q      <= S_IDLE;
         cnt_q     <= '0;
         ime_q     <= 1'b0;
         ei_pend_q <= 1'b0;
         halted_q  <= 1'b0;
         pcl_q     <= '0;
         spl_q     <= '0;
         vec_q     <= '0;
         wr_q      <= 1'b0;
         wraddr_q  <= '0;
         wrdata_q  <= '0;
         pc_load_q <= 1'b0;
         sp_load_q <= 1'b0;
         newpc_q   <= '0;
         newsp_q   <= '0;
      end else begin
         st_q      <= st_d;
         cnt_q     <= cnt_d;
         wr_q      <= 1'b0;
         wraddr_q  <= '0;
         wrdata_q  <= '0;
         pc_load_q <= 1'b0;
         sp_load_q <= 1'b0;
         newpc_q   <= '0;
         newsp_q   <= '0;
         if (bnd) begin
            if (di) begin
               ime_q     <= 1'b0;
               ei_pend_q <= 1'b0;
            end else if (reti) begin
               ime_q <= 1'b1;
            end else if (ei) begin
               ei_pend_q <= 1'b1;
            end else if (ei_pend_q) begin
               ime_q     <= 1'b1;
               ei_pend_q <= 1'b0;
            end
            if (halt && !intreq) halted_q <= 1'b1;
         end
         if (halted_q && intreq) halted_q <= 1'b0;
         if (start) begin
            pcl_q     <= pc;
            ime_q     <= 1'b0;
            ei_pend_q <= 1'b0;
         end
         // Strobes are decoded one clock early so they appear registered on the target clock.
         if (st_d == S_M3 && cnt_d == '0 && st_q == S_M2) begin
            wr_q     <= 1'b1;
            wraddr_q <= sp - 16'd1;
            wrdata_q <= pcl_q[15:8];
            spl_q    <= sp;
         end
         if (st_d == S_M4 && cnt_d == '0 && st_q == S_M3) begin
            wr_q     <= 1'b1;
            wraddr_q <= spl_q - 16'd2;
            wrdata_q <= pcl_q[7:0];
         end
         if (st_q == S_M4 && cnt_q == '0) vec_q <= intreq ? intaddress : 16'h0000;
         if (st_d == S_M5 && cnt_d == CLAST) begin
            pc_load_q <= 1'b1;
            sp_load_q <= 1'b1;
            newpc_q   <= vec_q;
            newsp_q   <= spl_q - 16'd2;
         end
      end
   end

   assign intack  = (st_q == S_M4) && (cnt_q == '0) && intreq;
   assign take    = (st_q != S_IDLE);
   assign halted  = halted_q;
   assign ime     = ime_q;
   assign wr      = wr_q;
   assign wraddr  = wraddr_q;
   assign wrdata  = wrdata_q;
   assign pc_load = pc_load_q;
   assign sp_load = sp_load_q;
   assign newpc   = newpc_q;
   assign newsp   = newsp_q;

endmodule

// File: tb/tb_int_dispatch.sv
// Directed bench for int_dispatch: EI/DI/RETI, HALT wake, dispatch pushes,
// cancelled dispatch, SP wrap and reset mid-dispatch.
module tb_int_dispatch;

   logic        clk = 1'b0, resetn = 1'b0;
   logic        intreq = 1'b0, boundary = 1'b0, ei = 1'b0, di = 1'b0, reti = 1'b0, halt = 1'b0;
   logic [15:0] intaddress = '0, pc = '0, sp = '0;
   logic        intack, take, halted, ime, wr, pc_load, sp_load;
   logic [15:0] wraddr, newpc, newsp;
   logic [7:0]  wrdata;

   int checks = 0, errors = 0;

   int          ntake, take_last, nwr, nack, ack_idx, npl, pl_idx;
   logic [15:0] wa [2];
   logic [7:0]  wd [2];
   int          widx [2];
   logic [15:0] npc, nsp;
   logic        spl;

   always #5 clk = ~clk;

   int_dispatch #(.MCYCLE(4)) dut (
      .clockgb(clk), .resetn(resetn), .intreq(intreq), .intaddress(intaddress),
      .intack(intack), .boundary(boundary), .ei(ei), .di(di), .reti(reti), .halt(halt),
      .pc(pc), .sp(sp), .take(take), .halted(halted), .ime(ime), .wr(wr),
      .wraddr(wraddr), .wrdata(wrdata), .pc_load(pc_load), .sp_load(sp_load),
      .newpc(newpc), .newsp(newsp)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // One boundary strobe with decode bits; returns at the next negedge.
   task automatic bnd(input logic e, input logic d, input logic r, input logic h);
      boundary = 1'b1; ei = e; di = d; reti = r; halt = h;
      @(negedge clk);
      boundary = 1'b0; ei = 1'b0; di = 1'b0; reti = 1'b0; halt = 1'b0;
   endtask

   // Watch 30 clocks from index 0; the flag clears on the edge after intack.
   task automatic monitor(input int drop_at);
      logic clr;
      clr = 1'b0;
      ntake = 0; take_last = -1; nwr = 0; nack = 0; ack_idx = -1; npl = 0; pl_idx = -1;
      npc = '0; nsp = '0; spl = 1'b0;
      for (int k = 0; k < 30; k++) begin
         if (clr) intreq = 1'b0;
         clr = 1'b0;
         if (take) begin ntake++; take_last = k; end
         if (wr) begin
            if (nwr < 2) begin wa[nwr] = wraddr; wd[nwr] = wrdata; widx[nwr] = k; end
            nwr++;
         end
         if (intack) begin nack++; ack_idx = k; clr = 1'b1; end
         if (pc_load) begin npl++; pl_idx = k; npc = newpc; nsp = newsp; spl = sp_load; end
         if (k == drop_at) intreq = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic expect_disp(input string t, input logic [15:0] a0, input logic [7:0] d0,
                              input logic [15:0] a1, input logic [7:0] d1, input int acks,
                              input logic [15:0] vpc, input logic [15:0] vsp);
      chk({t, "_ntake"}, ntake, 20);
      chk({t, "_take_last"}, take_last, 19);
      chk({t, "_nwr"}, nwr, 2);
      chk({t, "_wa0"}, wa[0], a0);
      chk({t, "_wd0"}, wd[0], d0);
      chk({t, "_widx0"}, widx[0], 8);
      chk({t, "_wa1"}, wa[1], a1);
      chk({t, "_wd1"}, wd[1], d1);
      chk({t, "_widx1"}, widx[1], 12);
      chk({t, "_nack"}, nack, acks);
      if (acks == 1) chk({t, "_ack_idx"}, ack_idx, 12);
      chk({t, "_npl"}, npl, 1);
      chk({t, "_pl_idx"}, pl_idx, 19);
      chk({t, "_sp_load"}, spl, 1);
      chk({t, "_newpc"}, npc, vpc);
      chk({t, "_newsp"}, nsp, vsp);
      chk({t, "_ime"}, ime, 0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_take", take, 0);
      chk("rst_ime", ime, 0);
      chk("rst_halted", halted, 0);
      chk("rst_wr", wr, 0);
      chk("rst_loads", {pc_load, sp_load, intack}, 0);
      chk("rst_newpc", newpc, 0);
      resetn = 1'b1;
      @(negedge clk);

      // Basic dispatch with IME set by RETI
      bnd(0, 0, 1, 0);
      chk("t1_ime_on", ime, 1);
      intreq = 1'b1; intaddress = 16'h0050; pc = 16'h1234; sp = 16'hFFFE;
      bnd(0, 0, 0, 0);
      monitor(-1);
      expect_disp("t1", 16'hFFFD, 8'h12, 16'hFFFC, 8'h34, 1, 16'h0050, 16'hFFFC);

      // EI takes effect one instruction late
      intreq = 1'b1; intaddress = 16'h0060; pc = 16'h2000; sp = 16'hD000;
      bnd(1, 0, 0, 0);
      chk("t2_no_take_after_ei", take, 0);
      chk("t2_ime_still_0", ime, 0);
      bnd(0, 0, 0, 0);
      monitor(-1);
      expect_disp("t2", 16'hCFFF, 8'h20, 16'hCFFE, 8'h00, 1, 16'h0060, 16'hCFFE);

      // EI then DI cancels the pending enable
      intreq = 1'b1;
      bnd(1, 0, 0, 0);
      chk("t3_take_ei", take, 0);
      bnd(0, 1, 0, 0);
      chk("t3_take_di", take, 0);
      bnd(0, 0, 0, 0);
      @(negedge clk);
      chk("t3_take_after", take, 0);
      chk("t3_ime", ime, 0);
      intreq = 1'b0;

      // Cancelled dispatch: request drops during M3
      bnd(0, 0, 1, 0);
      chk("t4_ime_on", ime, 1);
      intreq = 1'b1; intaddress = 16'h0048; pc = 16'hABCD; sp = 16'h8000;
      bnd(0, 0, 0, 0);
      monitor(9);
      expect_disp("t4", 16'h7FFF, 8'hAB, 16'h7FFE, 8'hCD, 0, 16'h0000, 16'h7FFE);

      // HALT with IME=0: wake without dispatch
      intreq = 1'b0;
      bnd(0, 0, 0, 1);
      chk("t5_halted", halted, 1);
      repeat (6) @(negedge clk);
      chk("t5_still_halted", halted, 1);
      intreq = 1'b1;
      @(negedge clk);
      chk("t5_woke", halted, 0);
      chk("t5_no_take", take, 0);
      @(negedge clk);
      chk("t5_no_take2", take, 0);
      // HALT with a request already pending does not halt
      bnd(0, 0, 0, 1);
      chk("t5_halt_pending", halted, 0);
      chk("t5_halt_pending_take", take, 0);
      intreq = 1'b0;

      // HALT with IME=1: wake straight into dispatch, SP wraps
      bnd(0, 0, 1, 0);
      bnd(0, 0, 0, 1);
      chk("t6_halted", halted, 1);
      chk("t6_ime", ime, 1);
      repeat (6) @(negedge clk);
      intreq = 1'b1; intaddress = 16'h0058; pc = 16'h0301; sp = 16'h0001;
      @(negedge clk);
      chk("t6_woke", halted, 0);
      chk("t6_take", take, 1);
      monitor(-1);
      expect_disp("t6", 16'h0000, 8'h03, 16'hFFFF, 8'h01, 1, 16'h0058, 16'hFFFF);

      // Reset asserted in M4 clock 0
      bnd(0, 0, 1, 0);
      intreq = 1'b1; intaddress = 16'h0040; pc = 16'h4444; sp = 16'hC000;
      bnd(0, 0, 0, 0);
      repeat (12) @(negedge clk);
      chk("t7_pre_wr", wr, 1);
      chk("t7_pre_ack", intack, 1);
      resetn = 1'b0;
      #1;
      chk("t7_take", take, 0);
      chk("t7_wr", wr, 0);
      chk("t7_ack", intack, 0);
      chk("t7_wraddr", wraddr, 0);
      chk("t7_ime", ime, 0);
      intreq = 1'b0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      monitor(-1);
      chk("t7_no_pc_load", npl, 0);
      chk("t7_no_take", ntake, 0);
      chk("t7_no_wr", nwr, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
